// File: rtl/led7seg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : led7seg_pkg
// Brief    : Segment bit positions, hex glyph table and pin polarity helper.
// Revision : 1.0
// ============================================================================
package led7seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high glyphs, entry 0 is the rightmost element.
    localparam logic [15:0][6:0] c_hex_seg = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [7:0] seg_polarity(input logic [7:0] bits, input logic active_low);
        return active_low ? ~bits : bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led7seg_decode.sv
`default_nettype none
// ============================================================================
// Module   : led7seg_decode
// Brief    : Nibble + decimal point to active-high 8-bit segment pattern.
// Revision : 1.0
// ============================================================================
module led7seg_decode
    import led7seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    input  logic       i_dark,
    output logic [7:0] o_pattern
);

    always_comb begin
        o_pattern                = '0;
        o_pattern[SEG_G:SEG_A]   = i_dark ? 7'h00 : c_hex_seg[i_nibble];
        o_pattern[SEG_DP]        = i_dp;
    end

endmodule
`default_nettype wire

// File: rtl/led7seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : led7seg_scan
// Brief    : Multiplexed 7-segment scanner with frame-shadowed inputs, PWM
//            brightness, dead-time guard and leading-zero suppression.
// Revision : 1.0
// ============================================================================
module led7seg_scan
    import led7seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_LOG2      = 17,
    parameter int GUARD          = 16,
    parameter int BRIGHT_W       = 3,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_en,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     segsel,
    output logic                  frame_start
);

    localparam int                   IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SCAN_LOG2-1:0] c_guard    = SCAN_LOG2'(GUARD);
    localparam logic [IDX_W-1:0]     c_last_idx = IDX_W'(DIGITS - 1);

    logic [SCAN_LOG2-1:0] r_p;
    logic [IDX_W-1:0]     r_idx;
    logic [4*DIGITS-1:0]  r_data;
    logic [DIGITS-1:0]    r_dp;
    logic [DIGITS-1:0]    r_blank;
    logic                 r_lz_en;
    logic [BRIGHT_W-1:0]  r_bright;
    logic [7:0]           r_seg;
    logic [DIGITS-1:0]    r_segsel;
    logic                 r_frame_start;

    logic                 w_boundary;
    logic [4*DIGITS-1:0]  w_data;
    logic [DIGITS-1:0]    w_dp;
    logic [DIGITS-1:0]    w_blank;
    logic                 w_lz_en;
    logic [BRIGHT_W-1:0]  w_bright;
    logic [DIGITS-1:0]    w_zero_tail;
    logic [DIGITS-1:0]    w_supp;
    logic [3:0]           w_nibble;
    logic                 w_dp_sel;
    logic                 w_blank_sel;
    logic                 w_supp_sel;
    logic [DIGITS-1:0]    w_onehot;
    logic                 w_on;
    logic [7:0]           w_pattern;

    assign w_boundary = (r_p == '0) && (r_idx == '0);

    // Bypass the shadows on the boundary cycle so even GUARD=0 never shows a stale digit.
    assign w_data   = w_boundary ? data   : r_data;
    assign w_dp     = w_boundary ? dp     : r_dp;
    assign w_blank  = w_boundary ? blank  : r_blank;
    assign w_lz_en  = w_boundary ? lz_en  : r_lz_en;
    assign w_bright = w_boundary ? bright : r_bright;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p   <= '0;
            r_idx <= '0;
        end else begin
            r_p <= r_p + 1'b1;
            if (&r_p) begin
                r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_dp     <= '0;
            r_blank  <= '1;
            r_lz_en  <= 1'b0;
            r_bright <= '0;
        end else if (w_boundary) begin
            r_data   <= data;
            r_dp     <= dp;
            r_blank  <= blank;
            r_lz_en  <= lz_en;
            r_bright <= bright;
        end
    end

    // A digit is a leading zero when it and every more-significant nibble is zero.
    always_comb begin
        w_zero_tail             = '0;
        w_zero_tail[DIGITS-1]   = (w_data[4*DIGITS-1 -: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            w_zero_tail[i] = w_zero_tail[i+1] && (w_data[4*i +: 4] == 4'h0);
        end
        w_supp    = w_lz_en ? w_zero_tail : '0;
        w_supp[0] = 1'b0;
    end

    always_comb begin
        w_nibble    = '0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        w_supp_sel  = 1'b0;
        w_onehot    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble    = w_data[4*i +: 4];
                w_dp_sel    = w_dp[i];
                w_blank_sel = w_blank[i];
                w_supp_sel  = w_supp[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    assign w_on = (r_p >= c_guard) &&
                  (r_p[SCAN_LOG2-1 -: BRIGHT_W] <= w_bright) &&
                  !w_blank_sel;

    led7seg_decode u_decode (
        .i_nibble  (w_nibble),
        .i_dp      (w_dp_sel && !w_blank_sel),
        .i_dark    (w_blank_sel || w_supp_sel),
        .o_pattern (w_pattern)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg         <= seg_polarity(8'h00, SEG_ACTIVE_LOW);
            r_segsel      <= {DIGITS{SEL_ACTIVE_LOW}};
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_boundary;
            if (w_on) begin
                r_seg    <= seg_polarity(w_pattern, SEG_ACTIVE_LOW);
                r_segsel <= w_onehot ^ {DIGITS{SEL_ACTIVE_LOW}};
            end else begin
                r_seg    <= seg_polarity(8'h00, SEG_ACTIVE_LOW);
                r_segsel <= {DIGITS{SEL_ACTIVE_LOW}};
            end
        end
    end

    assign seg         = r_seg;
    assign segsel      = r_segsel;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_led7seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_led7seg_scan
// Brief    : Randomised self-checking bench for led7seg_scan (4 digits, 16-cycle slots).
// Revision : 1.0
// ============================================================================
module tb_led7seg_scan;

    localparam int D   = 4;
    localparam int SL  = 4;
    localparam int G   = 2;
    localparam int BW  = 2;
    localparam int SLOT  = 1 << SL;
    localparam int FRAME = D * SLOT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   data = '0;
    logic [3:0]    dp = '0;
    logic [3:0]    blank = '0;
    logic          lz_en = 1'b0;
    logic [1:0]    bright = '0;
    logic [7:0]    seg;
    logic [3:0]    segsel;
    logic          frame_start;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led7seg_scan #(
        .DIGITS(D), .SCAN_LOG2(SL), .GUARD(G), .BRIGHT_W(BW),
        .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .blank(blank),
        .lz_en(lz_en), .bright(bright), .seg(seg), .segsel(segsel),
        .frame_start(frame_start)
    );

    // Reference: cycle count since reset release determines slot and digit.
    logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          m_t = 0;
    int          m_p, m_di;
    logic [15:0] s_data;
    logic [3:0]  s_dp, s_blank;
    logic        s_lz;
    logic [1:0]  s_bright;
    logic [3:0]  m_nib;
    logic [7:0]  m_pat;
    bit          m_lit, m_supp;
    logic [7:0]  e_seg = 8'hFF;
    logic [3:0]  e_sel = 4'hF;
    logic        e_fs = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_t = 0; s_data = '0; s_dp = '0; s_blank = '1; s_lz = 1'b0; s_bright = '0;
            e_seg = 8'hFF; e_sel = 4'hF; e_fs = 1'b0;
        end else begin
            m_p  = m_t % SLOT;
            m_di = (m_t / SLOT) % D;
            e_fs = (m_t % FRAME) == 0;
            if (e_fs) begin
                s_data = data; s_dp = dp; s_blank = blank; s_lz = lz_en; s_bright = bright;
            end
            m_nib  = s_data[4*m_di +: 4];
            m_supp = s_lz && (m_di != 0) && ((s_data >> (4*m_di)) == 16'h0);
            m_lit  = (m_p >= G) && ((m_p / (SLOT >> BW)) <= int'(s_bright)) && !s_blank[m_di];
            m_pat  = '0;
            if (!s_blank[m_di]) begin
                m_pat[7] = s_dp[m_di];
                if (!m_supp) m_pat[6:0] = hex_tab[m_nib];
            end
            e_seg = m_lit ? ~m_pat : 8'hFF;
            e_sel = m_lit ? ~(4'b0001 << m_di) : 4'hF;
            m_t++;
        end
    end

    // Returns at the negedge before a frame-boundary edge.
    task automatic align_frame();
        for (int i = 0; i < FRAME + 2; i++) begin
            @(negedge clk);
            if ((m_t % FRAME) == 0) return;
        end
    endtask

    task automatic test_reset();
        logic [7:0] xs;
        logic [3:0] xl;
        rst_n = 1'b0; data = 16'h12AF; bright = 2'd3; dp = '0; blank = '0; lz_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (seg !== 8'hFF || segsel !== 4'hF || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d seg=%h sel=%h fs=%b want FF/F/0", i, seg, segsel, frame_start);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1 || segsel !== 4'hF) begin
            errors++;
            $display("FAIL first_frame_start fs=%b sel=%h want 1/F", frame_start, segsel);
        end
        for (int c = 1; c < 2*SLOT; c++) begin
            @(negedge clk);
            if ((c % SLOT) < G) begin xs = 8'hFF; xl = 4'hF; end
            else if (c < SLOT) begin xs = 8'h8E; xl = 4'hE; end
            else begin xs = 8'h88; xl = 4'hD; end
            checks++;
            if (seg !== xs || segsel !== xl || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL slot_12AF c=%0d seg=%h sel=%h fs=%b want %h/%h/0", c, seg, segsel, frame_start, xs, xl);
            end
        end
    endtask

    task automatic test_bright(input logic [1:0] b);
        int on_cnt, want;
        bright = b; data = 16'($urandom); dp = 4'($urandom); blank = '0; lz_en = 1'b0;
        align_frame();
        on_cnt = 0;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (segsel !== 4'hF) on_cnt++;
            checks++;
            if (seg !== e_seg || segsel !== e_sel || frame_start !== e_fs) begin
                errors++;
                $display("FAIL bright%0d_cycle c=%0d seg=%h/%h sel=%h/%h fs=%b/%b", b, c, seg, e_seg, segsel, e_sel, frame_start, e_fs);
            end
        end
        want = D * ((int'(b) + 1) * (SLOT >> BW) - G);
        checks++;
        if (on_cnt != want) begin
            errors++;
            $display("FAIL bright%0d_on_count got=%0d want=%0d", b, on_cnt, want);
        end
    endtask

    task automatic test_lz();
        logic [7:0] xs;
        data = 16'h0050; lz_en = 1'b1; dp = 4'b1000; blank = '0; bright = 2'd3;
        align_frame();
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            case (segsel)
                4'b0111: xs = 8'h7F;
                4'b1101: xs = 8'h92;
                4'b1110: xs = 8'hC0;
                default: xs = 8'hFF;
            endcase
            checks++;
            if (seg !== xs || seg !== e_seg || segsel !== e_sel) begin
                errors++;
                $display("FAIL lz_0050 c=%0d seg=%h want %h sel=%h want %h", c, seg, xs, segsel, e_sel);
            end
        end
        data = 16'h0000; dp = 4'b0000;
        align_frame();
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            xs = (segsel == 4'b1110) ? 8'hC0 : 8'hFF;
            checks++;
            if (seg !== xs || segsel !== e_sel) begin
                errors++;
                $display("FAIL lz_zero c=%0d seg=%h want %h sel=%h want %h", c, seg, xs, segsel, e_sel);
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_midframe();
        logic [15:0] old_d;
        old_d = 16'($urandom); data = old_d; dp = '0; blank = '0; bright = 2'd3; lz_en = 1'b0;
        align_frame();
        for (int c = 0; c < 2*FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (seg !== e_seg || segsel !== e_sel || frame_start !== e_fs) begin
                errors++;
                $display("FAIL midframe c=%0d seg=%h/%h sel=%h/%h fs=%b/%b", c, seg, e_seg, segsel, e_sel, frame_start, e_fs);
            end
            if (c > 2*SLOT && c < FRAME && segsel == 4'b0111) begin
                checks++;
                if (seg !== {1'b1, ~hex_tab[old_d[15:12]]}) begin
                    errors++;
                    $display("FAIL midframe_old_value c=%0d seg=%h want %h", c, seg, {1'b1, ~hex_tab[old_d[15:12]]});
                end
            end
            if (c == 2*SLOT) data = ~old_d;
        end
    endtask

    task automatic test_blank();
        blank = 4'b0101; data = 16'($urandom); dp = 4'($urandom); bright = 2'd3; lz_en = 1'b0;
        align_frame();
        for (int c = 0; c < 2*FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (segsel[0] !== 1'b1 || segsel[2] !== 1'b1 || $countones(~segsel) > 1 ||
                seg !== e_seg || segsel !== e_sel) begin
                errors++;
                $display("FAIL blank_0101 c=%0d seg=%h/%h sel=%h/%h", c, seg, e_seg, segsel, e_sel);
            end
        end
        blank = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 8*FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (seg !== e_seg || segsel !== e_sel || frame_start !== e_fs || $countones(~segsel) > 1) begin
                errors++;
                $display("FAIL random c=%0d seg=%h/%h sel=%h/%h fs=%b/%b", c, seg, e_seg, segsel, e_sel, frame_start, e_fs);
            end
            if ($urandom_range(0, 19) == 0) begin
                data   = 16'($urandom);
                dp     = 4'($urandom);
                blank  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                lz_en  = 1'($urandom);
                bright = 2'($urandom);
                if ($urandom_range(0, 2) == 0) data[15:8] = 8'h00;
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        data = 16'h9E3C; dp = 4'b0110; blank = '0; bright = 2'd3; lz_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < FRAME + 2 && !found; i++) begin
            @(negedge clk);
            if ((m_t % FRAME) == 2*SLOT + 9) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid_reach m_t=%0d want slot 2 p 9", m_t);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (seg !== 8'hFF || segsel !== 4'hF || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_blank seg=%h sel=%h fs=%b want FF/F/0", seg, segsel, frame_start);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_restart fs=%b want 1", frame_start);
        end
        for (int c = 1; c < FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (seg !== e_seg || segsel !== e_sel || frame_start !== e_fs ||
                (c >= G && c < SLOT && segsel !== 4'hE)) begin
                errors++;
                $display("FAIL reset_mid_scan c=%0d seg=%h/%h sel=%h/%h fs=%b/%b", c, seg, e_seg, segsel, e_sel, frame_start, e_fs);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bright(2'd0);
        test_bright(2'd1);
        test_bright(2'd3);
        test_lz();
        test_midframe();
        test_blank();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
